// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, distance type and FSM states for the Hamming nearest-neighbour flow
package hamming_pkg;
    // Ceiling log2, with a minimum result of 1 so that an index of K=1 still gets one bit.
    function automatic int log2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int DEF_N  = 8;
    localparam int DEF_K  = 4;
    localparam int DEF_DW = 4;
    localparam int DEF_IW = log2(DEF_K);
    localparam int DEF_CW = 3;
    typedef logic [DEF_DW-1:0] dist_t;
    typedef enum logic {RUN, DONE} state_t;
endpackage

// File: rtl/hamming_nn_select.sv
// hamming_nn_select: tracks min distance/index and threshold match count over K candidate distances
//   clk, rst (sync, active-high)
//   dist_in/dist_valid : one distance per candidate from the Hamming unit
//   threshold          : match threshold, held stable during a search
//   min_dist/min_idx   : best distance so far and its candidate index
//   match_count        : candidates with distance <= threshold
//   below_thr          : min_dist <= threshold
//   done               : level, high once K distances are consumed, until rst
module hamming_nn_select
    import hamming_pkg::*;
#(
    parameter int K  = DEF_K,
    parameter int DW = DEF_DW,
    parameter int IW = DEF_IW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dist_in,
    input  logic          dist_valid,
    input  logic [DW-1:0] threshold,
    output logic [DW-1:0] min_dist,
    output logic [IW-1:0] min_idx,
    output logic [CW-1:0] match_count,
    output logic          below_thr,
    output logic          done
);
    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic          take, new_min;
    logic [DW-1:0] min_nxt;
    always_comb begin
        take      = state == RUN && dist_valid;
        new_min   = dist_in < min_dist;
        min_nxt   = take && new_min ? dist_in : min_dist;
        state_nxt = take && cnt == IW'(K - 1) ? DONE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            min_dist    <= '1;
            min_idx     <= '0;
            match_count <= '0;
            below_thr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                min_dist    <= min_nxt;
                min_idx     <= new_min ? cnt : min_idx;
                match_count <= match_count + CW'(dist_in <= threshold);
                // Uses the post-update minimum so it stays coherent with min_dist.
                below_thr   <= min_nxt <= threshold;
                // Holds at K-1 on the last candidate instead of wrapping.
                cnt         <= cnt + IW'(state_nxt == RUN);
            end
        end
    end
    assign done = state == DONE;
endmodule
